sum_chain_accum: RTL and testbench
==================================

SUM_CHAIN_ACCUM -- requirements
Module: sum_chain_accum

Interface
REQ-001 Parameter ACC_W, default 6, SHALL set the accumulator and out_sum width in bits; legal range 4..16.
REQ-002 Parameter LEN_W, default 4, SHALL set the width of the burst-length input.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  SHALL be a single-cycle request to begin a burst.
REQ-006 len  input  LEN_W  SHALL give the number of samples in the burst; sampled only when start is accepted.
REQ-007 in_valid  input  1  SHALL qualify in_r/in_c as a sample from the upstream 3-bit registered adder.
REQ-008 in_r  input  3  SHALL be the upstream 3-bit sum.
REQ-009 in_c  input  1  SHALL be the upstream carry-out.
REQ-010 in_ready  output  1  SHALL indicate this block accepts a sample this cycle.
REQ-011 out_valid  output  1  SHALL indicate out_sum/out_ovf hold a completed burst result.
REQ-012 out_ready  input  1  SHALL indicate the consumer takes the result.
REQ-013 out_sum  output  ACC_W  SHALL be the accumulated burst total, modulo 2^ACC_W.
REQ-014 out_ovf  output  1  SHALL flag that the burst total exceeded 2^ACC_W-1.
REQ-015 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-016 Each sample SHALL be the unsigned 4-bit value {in_c, in_r}, range 0..15.
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCUM and HOLD.
REQ-018 In IDLE with start=1 and len!=0, the next state SHALL be ACCUM, with acc=0, ovf=0 and remaining=len.
REQ-019 In IDLE with start=1 and len=0, the next state SHALL be HOLD, with acc=0 and ovf=0.
REQ-020 In IDLE with start=0, the block SHALL stay in IDLE and hold acc, ovf and out_sum unchanged.
REQ-021 in_ready SHALL be 1 only in ACCUM, as a function of state only (not combinationally dependent on in_valid).
REQ-022 A sample SHALL be accepted in a cycle only when in_valid=1 and in_ready=1.
REQ-023 On each accepted sample, the block SHALL update acc to (acc+sample) mod 2^ACC_W and decrement remaining by 1.
REQ-024 On any accepted sample whose add carries out of bit ACC_W-1, ovf SHALL be set; ovf SHALL stay set until the next accepted start or reset.
REQ-025 When the sample that brings remaining to 0 is accepted, the next state SHALL be HOLD, so out_valid asserts the cycle after the final sample (1-cycle latency).
REQ-026 In ACCUM with in_valid=0, acc, ovf and remaining SHALL hold, with no timeout.
REQ-027 out_valid SHALL be 1 only in HOLD, and out_sum/out_ovf SHALL stay stable while out_valid=1.
REQ-028 In HOLD with out_ready=1, the next state SHALL be IDLE; with out_ready=0, the block SHALL stay in HOLD indefinitely.
REQ-029 start SHALL be ignored in ACCUM and HOLD, including the HOLD cycle in which out_ready=1; a new burst needs a start in IDLE.
REQ-030 A start request SHALL NOT be queued, so back-to-back bursts have a minimum gap of one IDLE cycle.
REQ-031 len SHALL be captured only at start acceptance; later changes to len SHALL NOT affect the current burst.
REQ-032 For len=2^LEN_W-1 with all samples 15, out_sum SHALL equal (15*len) mod 2^ACC_W, with ovf set if 15*len > 2^ACC_W-1.
REQ-033 out_sum SHALL drive acc directly, and out_ovf SHALL drive the ovf flag directly; both are meaningful only while out_valid=1.

Reset
REQ-034 With rst=1 at a rising edge, the block SHALL enter IDLE with acc=0, ovf=0 and remaining=0, regardless of the current state.
REQ-035 Reset values SHALL be in_ready=0, out_valid=0, busy=0, out_sum=0 and out_ovf=0.
REQ-036 rst SHALL take priority over start, in_valid and out_ready in the same cycle.
REQ-037 A burst interrupted by reset mid-ACCUM or mid-HOLD SHALL be discarded, with no out_valid produced for it.

Verification
REQ-038 The bench SHALL cover: rst, then start with len=3 and samples {C,R}={0,1},{1,0},{0,5} -> out_valid one cycle after the 3rd sample, out_sum=14, out_ovf=0.
REQ-039 The bench SHALL cover: len=5 with five samples of 15 (C=1, R=7), ACC_W=6 -> out_sum=11, out_ovf=1.
REQ-040 The bench SHALL cover: len=0 start -> HOLD next cycle, out_sum=0, out_ovf=0, and in_ready never asserted.
REQ-041 The bench SHALL cover: in_valid gaps of 1-3 cycles within len=4 -> result equals the gap-free sum, and a start pulse during ACCUM is ignored.
REQ-042 The bench SHALL cover: out_ready held low 5 cycles -> out_valid and out_sum stable throughout, then IDLE one cycle after out_ready=1.
REQ-043 The bench SHALL cover: rst asserted after 2 of 4 samples -> IDLE with all outputs 0, and a following len=1 burst with sample 9 -> out_sum=9.

Source files
------------

// File: rtl/sum_chain_accum.sv
// sum_chain_accum
//   Accumulates a burst of 4-bit samples {in_c, in_r} coming from an upstream 3-bit
//   registered adder. A burst is requested with start/len in IDLE, samples are taken
//   with a valid/ready handshake in ACCUM, and the result is presented in HOLD until
//   the consumer takes it.
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_i        synchronous active-high reset
//   start_i      single-cycle burst request (only honoured in IDLE)
//   len_i        burst length, captured when start is accepted
//   in_valid_i   sample qualifier
//   in_r_i       upstream 3-bit sum
//   in_c_i       upstream carry-out
//   in_ready_o   block accepts a sample this cycle (ACCUM only)
//   out_valid_o  out_sum_o/out_ovf_o hold a completed burst result (HOLD only)
//   out_ready_i  consumer takes the result
//   out_sum_o    burst total modulo 2^ACC_W
//   out_ovf_o    burst total exceeded 2^ACC_W-1
//   busy_o       high in every state except IDLE

module sum_chain_accum #(
    parameter int unsigned ACC_W = 6,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             in_valid_i,
    input  logic [2:0]       in_r_i,
    input  logic             in_c_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_sum_o,
    output logic             out_ovf_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [LEN_W-1:0] rem_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    // One extra bit so the carry out of the accumulator MSB is visible.
    logic [ACC_W:0] sum;
    logic           accept;

    assign sum    = {1'b0, acc_q} + {{(ACC_W - 3){1'b0}}, in_c_i, in_r_i};
    assign accept = in_valid_i & in_ready_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            rem_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        acc_q  <= '0;
                        ovf_q  <= 1'b0;
                        rem_q  <= len_i;
                        busy_q <= 1'b1;
                        if (len_i != '0) begin
                            state_q    <= StAccum;
                            in_ready_q <= 1'b1;
                        end else begin
                            // Empty burst: report a zero result straight away.
                            state_q     <= StHold;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                StAccum: begin
                    if (accept) begin
                        acc_q <= sum[ACC_W-1:0];
                        if (sum[ACC_W]) begin
                            ovf_q <= 1'b1;
                        end
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_q     <= StHold;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                StHold: begin
                    // start is deliberately ignored here, even on the release cycle.
                    if (out_ready_i) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign out_sum_o   = acc_q;
    assign out_ovf_o   = ovf_q;

endmodule

// File: tb/tb_sum_chain_accum.sv
// Randomised bench for sum_chain_accum. Expected results come from summing the burst's
// samples as plain integers and reducing modulo 2^ACC_W.
module tb_sum_chain_accum;

    localparam int unsigned ACC_W = 6;
    localparam int unsigned LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [2:0]       in_r;
    logic             in_c;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [3:0] smp[$];

    sum_chain_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .len_i       (len),
        .in_valid_i  (in_valid),
        .in_r_i      (in_r),
        .in_c_i      (in_c),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sum_o   (out_sum),
        .out_ovf_o   (out_ovf),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the burst total as an ordinary integer.
    task automatic model(input int n, output logic [ACC_W-1:0] s, output logic o);
        int total = 0;
        for (int i = 0; i < n; i++) total += int'(smp[i]);
        s = ACC_W'(total % (1 << ACC_W));
        o = (total > (1 << ACC_W) - 1);
    endtask

    task automatic make_samples(input int n);
        smp.delete();
        for (int i = 0; i < n; i++) smp.push_back(4'($urandom_range(15, 0)));
    endtask

    task automatic begin_burst(input int n);
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        len   = LEN_W'($urandom);
    endtask

    // Drives smp[0..n-1]; optionally pulses start (len 7) in a gap before sample start_at.
    // Returns the number of samples the DUT never accepted within the wait bound.
    task automatic feed(input int n, input int min_gap, input int max_gap, input int start_at,
                        output int lost);
        lost = 0;
        for (int i = 0; i < n; i++) begin
            int gap;
            int k;
            bit took;
            gap = (max_gap > 0) ? $urandom_range(max_gap, min_gap) : 0;
            if (i == start_at && gap == 0) gap = 1;
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                {in_c, in_r} = 4'($urandom);
                if (i == start_at && g == 0) begin
                    start = 1'b1;
                    len   = LEN_W'(7);
                end
                tick();
                start = 1'b0;
            end
            in_valid = 1'b1;
            {in_c, in_r} = smp[i];
            k = 0;
            took = 1'b0;
            while (!took && k < 20) begin
                took = in_ready;
                tick();
                k++;
            end
            if (!took) lost++;
        end
        in_valid = 1'b0;
        {in_c, in_r} = 4'($urandom);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy, out_sum, out_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b sum=%0d ovf=%b, want all 0",
                     in_ready, out_valid, busy, out_sum, out_ovf);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_hold: busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int lost;
        smp = '{4'd1, 4'd8, 4'd5};
        begin_burst(3);
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b110) begin
            errors++;
            $display("FAIL basic_accum_state: busy/rdy/vld=%b want 110", {busy, in_ready, out_valid});
        end
        feed(3, 0, 0, -1, lost);
        checks++;
        if (lost !== 0 || out_valid !== 1'b1 || out_sum !== 6'd14 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: lost=%0d vld=%b sum=%0d ovf=%b want 0 1 14 0",
                     lost, out_valid, out_sum, out_ovf);
        end
        release_result();
        checks++;
        if ({busy, out_valid, in_ready} !== 3'b000) begin
            errors++;
            $display("FAIL basic_release: busy/vld/rdy=%b want 000", {busy, out_valid, in_ready});
        end
    endtask

    task automatic test_overflow(input int n);
        int lost;
        logic [ACC_W-1:0] es;
        logic eo;
        smp.delete();
        for (int i = 0; i < n; i++) smp.push_back(4'd15);
        model(n, es, eo);
        begin_burst(n);
        feed(n, 0, 0, -1, lost);
        checks++;
        if (lost !== 0 || out_valid !== 1'b1 || out_sum !== es || out_ovf !== eo) begin
            errors++;
            $display("FAIL overflow_len%0d: lost=%0d vld=%b sum=%0d ovf=%b want 0 1 %0d %b",
                     n, lost, out_valid, out_sum, out_ovf, es, eo);
        end
        release_result();
    endtask

    task automatic test_len_zero();
        in_valid = 1'b1;
        {in_c, in_r} = 4'd9;
        begin_burst(0);
        checks++;
        if ({out_valid, in_ready, busy, out_sum, out_ovf} !== {3'b101, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL len_zero: vld=%b rdy=%b busy=%b sum=%0d ovf=%b want 1 0 1 0 0",
                     out_valid, in_ready, busy, out_sum, out_ovf);
        end
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_sum !== 6'd0) begin
            errors++;
            $display("FAIL len_zero_hold: rdy=%b sum=%0d want 0 0", in_ready, out_sum);
        end
        in_valid = 1'b0;
        release_result();
    endtask

    task automatic test_gaps();
        int lost;
        logic [ACC_W-1:0] es;
        logic eo;
        make_samples(4);
        model(4, es, eo);
        begin_burst(4);
        feed(4, 1, 3, 2, lost);
        checks++;
        if (lost !== 0 || out_valid !== 1'b1 || out_sum !== es || out_ovf !== eo) begin
            errors++;
            $display("FAIL gaps_result: lost=%0d vld=%b sum=%0d ovf=%b want 0 1 %0d %b",
                     lost, out_valid, out_sum, out_ovf, es, eo);
        end
        release_result();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL gaps_start_ignored: busy=%b want 0", busy);
        end
    endtask

    task automatic test_hold_stall();
        int lost;
        logic [ACC_W-1:0] es;
        logic eo;
        make_samples(2);
        model(2, es, eo);
        begin_burst(2);
        feed(2, 0, 0, -1, lost);
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            checks++;
            if (out_valid !== 1'b1 || out_sum !== es || out_ovf !== eo) begin
                errors++;
                $display("FAIL hold_stable_c%0d: vld=%b sum=%0d ovf=%b want 1 %0d %b",
                         c, out_valid, out_sum, out_ovf, es, eo);
            end
            tick();
        end
        out_ready = 1'b1;
        start = 1'b1;
        len = LEN_W'(3);
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL hold_release: vld/busy=%b want 00", {out_valid, busy});
        end
        tick();
        checks++;
        if ({busy, in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL hold_release_start_ignored: busy/rdy=%b want 00", {busy, in_ready});
        end
    endtask

    task automatic test_reset_mid();
        int lost;
        make_samples(4);
        begin_burst(4);
        feed(2, 0, 0, -1, lost);
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy, out_sum, out_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_mid_accum: rdy=%b vld=%b busy=%b sum=%0d ovf=%b want all 0",
                     in_ready, out_valid, busy, out_sum, out_ovf);
        end
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_discard: vld=%b busy=%b want 0 0", out_valid, busy);
        end
        smp = '{4'd9};
        begin_burst(1);
        feed(1, 0, 0, -1, lost);
        checks++;
        if (lost !== 0 || out_valid !== 1'b1 || out_sum !== 6'd9 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_next: lost=%0d vld=%b sum=%0d ovf=%b want 0 1 9 0",
                     lost, out_valid, out_sum, out_ovf);
        end
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, busy, out_sum} !== '0) begin
            errors++;
            $display("FAIL reset_mid_hold: vld=%b busy=%b sum=%0d want 0 0 0",
                     out_valid, busy, out_sum);
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 25; b++) begin
            int n;
            int lost;
            int w;
            logic [ACC_W-1:0] es;
            logic eo;
            n = $urandom_range(15, 0);
            make_samples(n);
            model(n, es, eo);
            begin_burst(n);
            feed(n, 0, 2, -1, lost);
            checks++;
            if (lost !== 0 || out_valid !== 1'b1 || out_sum !== es || out_ovf !== eo) begin
                errors++;
                $display("FAIL random_b%0d_len%0d: lost=%0d vld=%b sum=%0d ovf=%b want 0 1 %0d %b",
                         b, n, lost, out_valid, out_sum, out_ovf, es, eo);
            end
            w = $urandom_range(2, 0);
            repeat (w) tick();
            release_result();
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL random_b%0d_idle: busy=%b want 0", b, busy);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        len = '0;
        in_valid = 1'b0;
        in_r = '0;
        in_c = 1'b0;
        out_ready = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_overflow(5);
        test_len_zero();
        test_gaps();
        test_hold_stall();
        test_reset_mid();
        test_overflow(15);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
